axi4_lite_multi_read_master: RTL and testbench

- Parametrised AXI4-Lite read master that takes a command (start address, beat count) and issues a run of incrementing single-beat reads.
- Supports up to MAX_OUTSTANDING reads in flight. AR and R channels are decoupled.
- Read data is returned on a registered valid/ready stream with response code and last flag.
- Sits between local DMA/config-scan logic and the AXI4-Lite interconnect. It is the pipelined successor to the single-transaction read master.

---
 rtl/axi4_lite_multi_read_master.sv | 190 +++++++++++++++++++
 tb/tb_axi4_lite_multi_read_master.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_multi_read_master.sv
// axi4_lite_multi_read_master
//   Pipelined AXI4-Lite read master. It accepts a command (start address and
//   beat count minus one) and issues a run of incrementing single-beat reads.
//   Up to MAX_OUTSTANDING reads may be in flight. AR and R are decoupled.
//   Read beats are returned on a registered valid/ready stream with the
//   response code and a last flag.
//
// Ports
//   clk, resetn             clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake (cmd_ready high only when idle)
//   cmd_addr, cmd_len       start address (beat aligned), beats minus one
//   out_valid/out_ready     returned-beat stream handshake
//   out_data/out_resp       captured RDATA / RRESP
//   out_last                final beat of the command
//   busy                    high while a command is active
//   err                     sticky: any RRESP[1] or watchdog expiry; cleared on accept
//   timeout                 sticky watchdog flag (0 when the watchdog is not built)
//   ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY  AXI4-Lite read channels
//
// Build option
//   AXI4LITE_RD_TIMEOUT_EN  builds a watchdog that sets timeout/err after
//                           TIMEOUT_CYCLES cycles with reads outstanding and
//                           no R handshake.
module axi4_lite_multi_read_master #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned LEN_WIDTH       = 8,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            out_resp,
    output logic                  out_last,
    output logic                  busy,
    output logic                  err,
    output logic                  timeout,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [2:0]            ARPROT,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RVALID,
    output logic                  RREADY
);

    if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_data_width
        $error("DATA_WIDTH must be 32 or 64");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15) begin : g_bad_max_outstanding
        $error("MAX_OUTSTANDING must be in 1..15");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [3:0]            MAX_OUT   = 4'(MAX_OUTSTANDING);
    localparam logic [LEN_WIDTH:0]    CNT_ONE   = (LEN_WIDTH+1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH:0]    issue_rem;
    logic [LEN_WIDTH:0]    recv_rem;
    logic [3:0]            outstanding;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  out_hs;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign ARADDR    = addr_q;
    assign ARPROT    = 3'b000;
    // Derived only from registers that change on the AR handshake itself,
    // so ARVALID/ARADDR cannot drop or move while waiting for ARREADY.
    assign ARVALID   = (state == RUN) && (issue_rem != '0) && (outstanding < MAX_OUT);
    assign RREADY    = busy && (!out_valid || out_ready);

    assign ar_hs  = ARVALID && ARREADY;
    // A beat with nothing outstanding is a slave protocol error and is dropped.
    assign r_hs   = RVALID && RREADY && (outstanding != '0);
    assign out_hs = out_valid && out_ready;

`ifdef AXI4LITE_RD_TIMEOUT_EN
    localparam int unsigned       WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            timeout_q;

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            addr_q      <= '0;
            issue_rem   <= '0;
            recv_rem    <= '0;
            outstanding <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_resp    <= '0;
            out_last    <= 1'b0;
            err         <= 1'b0;
`ifdef AXI4LITE_RD_TIMEOUT_EN
            wd_cnt      <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state     <= RUN;
                        addr_q    <= cmd_addr;
                        issue_rem <= (LEN_WIDTH+1)'(cmd_len) + CNT_ONE;
                        recv_rem  <= (LEN_WIDTH+1)'(cmd_len) + CNT_ONE;
                        err       <= 1'b0;
`ifdef AXI4LITE_RD_TIMEOUT_EN
                        timeout_q <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (ar_hs) begin
                        addr_q    <= addr_q + ADDR_STEP;
                        issue_rem <= issue_rem - CNT_ONE;
                        if (issue_rem == CNT_ONE) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_hs && out_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            case ({ar_hs, r_hs})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   outstanding <= outstanding - 4'd1;
                default: outstanding <= outstanding;
            endcase

            // RREADY already guarantees the register is empty or being drained.
            if (r_hs) begin
                out_valid <= 1'b1;
                out_data  <= RDATA;
                out_resp  <= RRESP;
                out_last  <= (recv_rem == CNT_ONE);
                recv_rem  <= recv_rem - CNT_ONE;
                if (RRESP[1]) begin
                    err <= 1'b1;
                end
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end

`ifdef AXI4LITE_RD_TIMEOUT_EN
            if ((outstanding != '0) && !r_hs) begin
                if (wd_cnt != WD_LIMIT) begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
                if (wd_cnt == WD_LAST) begin
                    timeout_q <= 1'b1;
                    err       <= 1'b1;
                end
            end else begin
                wd_cnt <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_axi4_lite_multi_read_master.sv
// Testbench for axi4_lite_multi_read_master: directed scenarios plus randomized
// commands, with a slave model and a transaction-level reference model.
module tb_axi4_lite_multi_read_master;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned MAXO = 4;
    localparam int unsigned LW   = 8;
    localparam int unsigned TO   = 16;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [1:0]    out_resp;
    logic          out_last;
    logic          busy;
    logic          err;
    logic          timeout;
    logic [AW-1:0] ARADDR;
    logic [2:0]    ARPROT;
    logic          ARVALID;
    logic          ARREADY = 1'b0;
    logic [DW-1:0] RDATA = '0;
    logic [1:0]    RRESP = '0;
    logic          RVALID = 1'b0;
    logic          RREADY;

    always #5 clk = ~clk;

    axi4_lite_multi_read_master #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MAXO),
        .LEN_WIDTH       (LW),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_resp  (out_resp),
        .out_last  (out_last),
        .busy      (busy),
        .err       (err),
        .timeout   (timeout),
        .ARADDR    (ARADDR),
        .ARPROT    (ARPROT),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .RDATA     (RDATA),
        .RRESP     (RRESP),
        .RVALID    (RVALID),
        .RREADY    (RREADY)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: command-level view of what the master should be doing.
    bit            active = 0;
    bit            ov_exp = 0;
    bit            err_exp = 0;
    bit            to_exp = 0;
    int unsigned   n_beats = 0;
    int unsigned   issued = 0;
    int unsigned   r_idx = 0;
    int unsigned   ov_idx = 0;
    int unsigned   consumed = 0;
    int unsigned   outst = 0;
    int unsigned   max_outst = 0;
    int unsigned   cyc = 0;
    int unsigned   to_cnt = 0;
    logic [AW-1:0] base = '0;
    logic [DW-1:0] rdata_arr [256];
    logic [1:0]    rresp_arr [256];
    int unsigned   due_q [$];

    // Slave / consumer behaviour knobs.
    int unsigned   ar_pct = 100;
    int unsigned   or_pct = 100;
    int unsigned   dmin = 1;
    int unsigned   dmax = 1;
    int unsigned   ar_limit = 1000;
    int unsigned   bp_left = 0;
    bit            spurious = 0;
    bit            cmd_pend = 0;
    logic [AW-1:0] cmd_a = '0;
    logic [LW-1:0] cmd_l = '0;

    task automatic fill_random(input int unsigned len);
        for (int i = 0; i <= int'(len); i++) begin
            rdata_arr[i] = $urandom;
            rresp_arr[i] = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
        end
    endtask

    // One clock: drive inputs on the falling edge, check outputs 1 time unit
    // later, then advance the model by the handshakes the next rising edge takes.
    task automatic cycle();
        bit            ar_hs;
        bit            r_hs;
        bit            out_hs;
        bit            acc;
        bit            exp_arv;
        bit            exp_rr;
        logic [AW-1:0] ea;
        @(negedge clk);
        cmd_valid = cmd_pend;
        cmd_addr  = cmd_a;
        cmd_len   = cmd_l;
        ARREADY   = (!active || issued < ar_limit) && ($urandom_range(0, 99) < ar_pct);
        if (bp_left > 0) begin
            out_ready = 1'b0;
            bp_left--;
        end else begin
            out_ready = ($urandom_range(0, 99) < or_pct);
        end
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
            RVALID = 1'b1;
            RDATA  = rdata_arr[r_idx];
            RRESP  = rresp_arr[r_idx];
        end else begin
            RVALID = spurious;
            RDATA  = $urandom;
            RRESP  = 2'($urandom);
        end
        #1;
        exp_arv = active && (issued < n_beats) && (outst < MAXO);
        exp_rr  = active && (!ov_exp || out_ready);
        ea      = base + AW'(issued * 4);
        check("cmd_ready", 64'(cmd_ready), 64'(!active));
        check("busy", 64'(busy), 64'(active));
        check("arvalid", 64'(ARVALID), 64'(exp_arv));
        if (exp_arv) check("araddr", 64'(ARADDR), 64'(ea));
        check("arprot", 64'(ARPROT), 64'(0));
        check("rready", 64'(RREADY), 64'(exp_rr));
        check("out_valid", 64'(out_valid), 64'(ov_exp));
        if (ov_exp) begin
            check("out_data", 64'(out_data), 64'(rdata_arr[ov_idx]));
            check("out_resp", 64'(out_resp), 64'(rresp_arr[ov_idx]));
            check("out_last", 64'(out_last), 64'(ov_idx == n_beats - 1));
        end
        check("err", 64'(err), 64'(err_exp));
        check("timeout", 64'(timeout), 64'(to_exp));

        ar_hs  = ARVALID && ARREADY;
        r_hs   = RVALID && RREADY && (outst > 0);
        out_hs = out_valid && out_ready;
        acc    = cmd_valid && cmd_ready;

`ifdef AXI4LITE_RD_TIMEOUT_EN
        if (outst > 0 && !r_hs) begin
            to_cnt++;
            if (to_cnt == TO) begin
                to_exp  = 1;
                err_exp = 1;
            end
        end else begin
            to_cnt = 0;
        end
`endif
        if (ar_hs) begin
            due_q.push_back(cyc + $urandom_range(dmax, dmin));
            issued++;
        end
        if (out_hs) begin
            consumed++;
            if (consumed == n_beats) active = 0;
        end
        if (r_hs) begin
            void'(due_q.pop_front());
            if (rresp_arr[r_idx][1]) err_exp = 1;
            ov_exp = 1;
            ov_idx = r_idx;
            r_idx++;
        end else if (out_hs) begin
            ov_exp = 0;
        end
        outst = outst + (ar_hs ? 1 : 0) - (r_hs ? 1 : 0);
        if (outst > max_outst) max_outst = outst;
        if (acc) begin
            active   = 1;
            n_beats  = int'(cmd_l) + 1;
            base     = cmd_a;
            issued   = 0;
            r_idx    = 0;
            consumed = 0;
            err_exp  = 0;
            to_exp   = 0;
            to_cnt   = 0;
            cmd_pend = 0;
        end
        cyc++;
    endtask

    task automatic start_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l);
        cmd_pend = 1;
        cmd_a    = a;
        cmd_l    = l;
    endtask

    task automatic wait_done(input int unsigned budget);
        int unsigned k = 0;
        while ((active || cmd_pend) && k < budget) begin
            cycle();
            k++;
        end
        check("done_in_budget", 64'(active || cmd_pend), 64'(0));
        check("beats_delivered", 64'(consumed), 64'(n_beats));
        if (active || cmd_pend) begin
            $display("FAIL command_stuck got=busy exp=idle");
            $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
            $fatal(1, "command did not complete");
        end
        cycle();
    endtask

    task automatic run_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l, input int unsigned budget);
        start_cmd(a, l);
        wait_done(budget);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_arvalid", 64'(ARVALID), 64'(0));
        check("rst_araddr", 64'(ARADDR), 64'(0));
        check("rst_rready", 64'(RREADY), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_last", 64'(out_last), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_timeout", 64'(timeout), 64'(0));
        @(negedge clk);
        resetn = 1'b1;

        // Stray R beat while idle must be ignored.
        spurious = 1;
        repeat (3) cycle();
        spurious = 0;

        // Single read.
        rdata_arr[0] = 32'hDEADBEEF;
        rresp_arr[0] = 2'b00;
        run_cmd(32'h0000_0100, 8'd0, 50);

        // Pipelined run: fills the outstanding window.
        fill_random(7);
        dmin = 4; dmax = 4; max_outst = 0;
        run_cmd(32'h0000_1000, 8'd7, 200);
        check("pipe_max_outst", 64'(max_outst), 64'(MAXO));

        // Backpressure mid-run.
        fill_random(11);
        dmin = 2; dmax = 2; max_outst = 0;
        start_cmd(32'h0000_2000, 8'd11);
        repeat (5) cycle();
        bp_left = 10;
        wait_done(300);
        check("bp_max_outst", 64'(max_outst), 64'(MAXO));

        // Error response and address wrap.
        dmin = 1; dmax = 3;
        rdata_arr[0] = 32'h1111_2222; rresp_arr[0] = 2'b00;
        rdata_arr[1] = 32'h3333_4444; rresp_arr[1] = 2'b10;
        run_cmd(32'hFFFF_FFFC, 8'd1, 60);
        check("wrap_err_sticky", 64'(err), 64'(1));
        fill_random(2);
        for (int i = 0; i <= 2; i++) rresp_arr[i] = 2'b00;
        start_cmd(32'h0000_0200, 8'd2);
        cycle();
        cycle();
        check("err_cleared_on_accept", 64'(err), 64'(0));
        wait_done(60);

        // Reset with three reads in flight and ARVALID stalled.
        fill_random(9);
        dmin = 60; dmax = 60; ar_limit = 3;
        start_cmd(32'h0000_3000, 8'd9);
        repeat (8) cycle();
        check("pre_reset_arvalid", 64'(ARVALID), 64'(1));
        resetn = 1'b0;
        #1;
        check("async_rst_arvalid", 64'(ARVALID), 64'(0));
        check("async_rst_rready", 64'(RREADY), 64'(0));
        check("async_rst_out_valid", 64'(out_valid), 64'(0));
        check("async_rst_busy", 64'(busy), 64'(0));
        check("async_rst_cmd_ready", 64'(cmd_ready), 64'(1));
        active = 0; ov_exp = 0; err_exp = 0; to_exp = 0; to_cnt = 0;
        outst = 0; issued = 0; n_beats = 0; due_q.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        ar_limit = 1000; dmin = 1; dmax = 3;
        fill_random(3);
        run_cmd(32'h0000_0040, 8'd3, 80);

`ifdef AXI4LITE_RD_TIMEOUT_EN
        // Watchdog: R withheld past the limit, beat still delivered.
        rdata_arr[0] = 32'hCAFE_F00D; rresp_arr[0] = 2'b00;
        dmin = 21; dmax = 21;
        run_cmd(32'h0000_0300, 8'd0, 100);
        check("wd_timeout", 64'(timeout), 64'(1));
        check("wd_err", 64'(err), 64'(1));
        dmin = 1; dmax = 3;
`endif

        // Randomized commands.
        for (int n = 0; n < 40; n++) begin
            int unsigned len;
            logic [AW-1:0] a;
            len    = (n == 0) ? 255 : $urandom_range(0, 15);
            a      = $urandom;
            a[1:0] = 2'b00;
            ar_pct = $urandom_range(20, 100);
            or_pct = $urandom_range(20, 100);
            dmin   = 1;
            dmax   = $urandom_range(1, 6);
            fill_random(len);
            run_cmd(a, LW'(len), (len + 1) * 60 + 100);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
